// File: rtl/rat_io_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : rat_io_responder_if
// Description : MCU port I/O bus between the MCU (master) and a peripheral
//               responder (slave).
//   PORT_ID      port address from the MCU
//   OUT_PORT     write data from the MCU
//   IO_STRB      one-cycle write strobe from the MCU
//   IN_PORT      read data returned to the MCU (combinational)
//   INTERUPT_OUT level interrupt request to the MCU
// Revision    : 1.0 - initial release
// ============================================================================
interface rat_io_responder_if;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] IN_PORT;
    logic       INTERUPT_OUT;

    modport master (
        output PORT_ID,
        output OUT_PORT,
        output IO_STRB,
        input  IN_PORT,
        input  INTERUPT_OUT
    );

    modport slave (
        input  PORT_ID,
        input  OUT_PORT,
        input  IO_STRB,
        output IN_PORT,
        output INTERUPT_OUT
    );
endinterface
`default_nettype wire

// File: rtl/rat_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : rat_io_responder
// Description : Peripheral-side responder for the MCU port I/O bus. Holds the
//               LED and seven-segment registers, debounces a button into a
//               latched interrupt, and buffers an external byte stream in a
//               small FIFO that the CPU reads and pops through ports.
// Ports       :
//   CLK        system clock (shared with the MCU)
//   RESET_N    asynchronous active-low reset
//   bus        MCU port bus (slave modport): PORT_ID/OUT_PORT/IO_STRB in,
//              IN_PORT/INTERUPT_OUT out
//   SWITCHES   slide switches, readable on port 0x20
//   BTN_RAW    asynchronous button input
//   RX_DATA    incoming byte, RX_VALID producer valid, RX_READY = !full
//   LEDS       LED register (port 0x40)
//   SSEG_VAL   seven-segment value register (port 0x81)
// Options     : define RAT_IO_READBACK_EN to make ports 0x40/0x81 readable.
// Revision    : 1.0 - initial release
// ============================================================================
module rat_io_responder #(
    parameter int FIFO_DEPTH      = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    rat_io_responder_if.slave        bus,
    input  logic [7:0]               SWITCHES,
    input  logic                     BTN_RAW,
    input  logic [7:0]               RX_DATA,
    input  logic                     RX_VALID,
    output logic                     RX_READY,
    output logic [7:0]               LEDS,
    output logic [7:0]               SSEG_VAL
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [c_CW-1:0] c_FULL_COUNT = c_CW'(FIFO_DEPTH);
    localparam logic [c_DW-1:0] c_DB_LAST    = c_DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [7:0] c_PORT_SWITCHES = 8'h20;
    localparam logic [7:0] c_PORT_FIFO_RD  = 8'h30;
    localparam logic [7:0] c_PORT_FIFO_ST  = 8'h31;
    localparam logic [7:0] c_PORT_IRQ_ST   = 8'h32;
    localparam logic [7:0] c_PORT_FIFO_POP = 8'h33;
    localparam logic [7:0] c_PORT_LEDS     = 8'h40;
    localparam logic [7:0] c_PORT_SSEG     = 8'h81;
    localparam logic [7:0] c_PORT_IRQ_CTL  = 8'hF0;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic w_wr_leds, w_wr_sseg, w_wr_irq, w_wr_pop;

    assign w_wr_leds = bus.IO_STRB && (bus.PORT_ID == c_PORT_LEDS);
    assign w_wr_sseg = bus.IO_STRB && (bus.PORT_ID == c_PORT_SSEG);
    assign w_wr_irq  = bus.IO_STRB && (bus.PORT_ID == c_PORT_IRQ_CTL);
    assign w_wr_pop  = bus.IO_STRB && (bus.PORT_ID == c_PORT_FIFO_POP);

    logic [7:0] r_leds, r_sseg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_leds <= 8'h00;
            r_sseg <= 8'h00;
        end else begin
            if (w_wr_leds) r_leds <= bus.OUT_PORT;
            if (w_wr_sseg) r_sseg <= bus.OUT_PORT;
        end
    end

    assign LEDS     = r_leds;
    assign SSEG_VAL = r_sseg;

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_empty, w_full, w_push, w_pop;
    logic [7:0]      w_head;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL_COUNT);
    assign RX_READY = !w_full;
    assign w_push   = RX_VALID && !w_full;
    assign w_pop    = w_wr_pop && !w_empty;
    assign w_head   = w_empty ? 8'h00 : r_mem[r_rd_ptr];

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= RX_DATA;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Button synchronizer and debounce
    // ------------------------------------------------------------------
    logic            r_btn_meta, r_btn_sync, r_btn_db;
    logic [c_DW-1:0] r_db_cnt;
    logic            w_db_flip, w_db_rise;

    // The debounced value flips on the DEBOUNCE_CYCLES-th consecutive
    // differing sample.
    assign w_db_flip = (r_btn_sync != r_btn_db) && (r_db_cnt == c_DB_LAST);
    assign w_db_rise = w_db_flip && r_btn_sync;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_btn_db   <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_btn_meta <= BTN_RAW;
            r_btn_sync <= r_btn_meta;
            if (r_btn_sync == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (w_db_flip) begin
                r_btn_db <= r_btn_sync;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_DW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt control
    // ------------------------------------------------------------------
    logic r_btn_pending, r_mask_btn, r_mask_fifo, r_irq;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_btn_pending <= 1'b0;
            r_mask_btn    <= 1'b0;
            r_mask_fifo   <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            // A new button edge wins over an acknowledge in the same cycle.
            if (w_db_rise)
                r_btn_pending <= 1'b1;
            else if (w_wr_irq && bus.OUT_PORT[0])
                r_btn_pending <= 1'b0;
            if (w_wr_irq) begin
                r_mask_btn  <= bus.OUT_PORT[1];
                r_mask_fifo <= bus.OUT_PORT[2];
            end
            r_irq <= (r_btn_pending && r_mask_btn) || (!w_empty && r_mask_fifo);
        end
    end

    assign bus.INTERUPT_OUT = r_irq;

    // ------------------------------------------------------------------
    // Read mux: combinational, the MCU samples it in its execute cycle.
    // ------------------------------------------------------------------
    always_comb begin
        bus.IN_PORT = 8'h00;
        case (bus.PORT_ID)
            c_PORT_SWITCHES: bus.IN_PORT = SWITCHES;
            c_PORT_FIFO_RD:  bus.IN_PORT = w_head;
            c_PORT_FIFO_ST:  bus.IN_PORT = {w_full, w_empty, 6'(r_count)};
            c_PORT_IRQ_ST:   bus.IN_PORT = {5'b0, r_mask_fifo, r_mask_btn, r_btn_pending};
`ifdef RAT_IO_READBACK_EN
            c_PORT_LEDS:     bus.IN_PORT = r_leds;
            c_PORT_SSEG:     bus.IN_PORT = r_sseg;
`endif
            default:         bus.IN_PORT = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rat_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rat_io_responder
// Description : Self-checking bench for rat_io_responder: a vector table for
//               single-cycle register writes/reads, plus hand-written
//               sequences for FIFO, debounce, interrupt and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rat_io_responder;

`ifdef RAT_IO_READBACK_EN
    localparam logic [7:0] c_RB_LEDS = 8'hA5;
    localparam logic [7:0] c_RB_SSEG = 8'h7E;
`else
    localparam logic [7:0] c_RB_LEDS = 8'h00;
    localparam logic [7:0] c_RB_SSEG = 8'h00;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] SWITCHES;
    logic       BTN_RAW;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic [7:0] LEDS;
    logic [7:0] SSEG_VAL;

    rat_io_responder_if bus ();

    rat_io_responder #(
        .FIFO_DEPTH      (8),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .bus      (bus),
        .SWITCHES (SWITCHES),
        .BTN_RAW  (BTN_RAW),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .LEDS     (LEDS),
        .SSEG_VAL (SSEG_VAL)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] wr_port;
        logic [7:0] wr_data;
        logic       strb;
        logic [7:0] rd_port;
        logic [7:0] exp_rd;
        logic [7:0] exp_leds;
        logic [7:0] exp_sseg;
    } vec_t;

    vec_t vecs [10];
    logic [7:0] q [$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h required 0x%02h", nm, act, exp);
        end
    endtask

    // Reads are taken between clock edges (just after a falling edge).
    task automatic rd_chk(input string nm, input logic [7:0] p, input logic [7:0] exp);
        bus.PORT_ID = p;
        #1;
        chk(nm, bus.IN_PORT, exp);
    endtask

    task automatic bus_write(input logic [7:0] p, input logic [7:0] d, input logic s);
        @(negedge CLK);
        bus.PORT_ID  = p;
        bus.OUT_PORT = d;
        bus.IO_STRB  = s;
        @(negedge CLK);
        bus.IO_STRB  = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA      = b;
        RX_VALID     = 1'b1;
        bus.PORT_ID  = 8'h33;
        bus.IO_STRB  = 1'b1;
        @(negedge CLK);
        RX_VALID     = 1'b0;
        bus.IO_STRB  = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen;

        RESET_N      = 1'b0;
        SWITCHES     = 8'h5A;
        BTN_RAW      = 1'b0;
        RX_DATA      = 8'h00;
        RX_VALID     = 1'b0;
        bus.PORT_ID  = 8'h00;
        bus.OUT_PORT = 8'h00;
        bus.IO_STRB  = 1'b0;

        //               wr_port wr_data strb rd_port exp_rd    leds   sseg
        vecs[0] = '{8'h40, 8'hA5, 1'b1, 8'h20, 8'h5A,    8'hA5, 8'h00};
        vecs[1] = '{8'h40, 8'h3C, 1'b0, 8'h31, 8'h40,    8'hA5, 8'h00};
        vecs[2] = '{8'h55, 8'hFF, 1'b1, 8'h32, 8'h00,    8'hA5, 8'h00};
        vecs[3] = '{8'h81, 8'h7E, 1'b1, 8'h30, 8'h00,    8'hA5, 8'h7E};
        vecs[4] = '{8'hF0, 8'h06, 1'b1, 8'h32, 8'h06,    8'hA5, 8'h7E};
        vecs[5] = '{8'hF0, 8'h00, 1'b1, 8'h32, 8'h00,    8'hA5, 8'h7E};
        vecs[6] = '{8'h33, 8'h00, 1'b1, 8'h31, 8'h40,    8'hA5, 8'h7E};
        vecs[7] = '{8'h20, 8'h12, 1'b1, 8'h40, c_RB_LEDS, 8'hA5, 8'h7E};
        vecs[8] = '{8'h81, 8'h99, 1'b0, 8'h81, c_RB_SSEG, 8'hA5, 8'h7E};
        vecs[9] = '{8'h99, 8'h44, 1'b1, 8'h99, 8'h00,    8'hA5, 8'h7E};

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_leds", LEDS, 8'h00);
        chk("rst_sseg", SSEG_VAL, 8'h00);
        chk("rst_irq", {7'b0, bus.INTERUPT_OUT}, 8'h00);
        chk("rst_rx_ready", {7'b0, RX_READY}, 8'h01);
        rd_chk("rst_status", 8'h31, 8'h40);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Register write/read table
        for (int i = 0; i < 10; i++) begin
            bus_write(vecs[i].wr_port, vecs[i].wr_data, vecs[i].strb);
            rd_chk($sformatf("vec%0d_rd", i), vecs[i].rd_port, vecs[i].exp_rd);
            chk($sformatf("vec%0d_leds", i), LEDS, vecs[i].exp_leds);
            chk($sformatf("vec%0d_sseg", i), SSEG_VAL, vecs[i].exp_sseg);
        end

        // FIFO fill to full, then drain in order
        for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
        chk("full_rx_ready", {7'b0, RX_READY}, 8'h00);
        rd_chk("full_status", 8'h31, 8'h88);
        for (int i = 1; i <= 8; i++) begin
            rd_chk($sformatf("drain_head%0d", i), 8'h30, 8'(i * 8'h11));
            bus_write(8'h33, 8'h00, 1'b1);
        end
        rd_chk("drained_status", 8'h31, 8'h40);
        rd_chk("drained_head", 8'h30, 8'h00);
        bus_write(8'h33, 8'h00, 1'b1);
        rd_chk("extra_pop_status", 8'h31, 8'h40);
        chk("extra_pop_rx_ready", {7'b0, RX_READY}, 8'h01);

        // Simultaneous push/pop at count 3, then wrap via 20 pairs
        q.delete();
        for (int i = 0; i < 3; i++) begin
            push(8'(8'hA1 + i));
            q.push_back(8'(8'hA1 + i));
        end
        push_pop(8'hA4);
        void'(q.pop_front());
        q.push_back(8'hA4);
        rd_chk("pp_status", 8'h31, 8'h03);
        rd_chk("pp_head", 8'h30, 8'hA2);
        for (int i = 0; i < 20; i++) begin
            rd_chk($sformatf("wrap_head%0d", i), 8'h30, q[0]);
            push_pop(8'(8'hB0 + i));
            void'(q.pop_front());
            q.push_back(8'(8'hB0 + i));
        end
        while (q.size() > 0) begin
            rd_chk("wrap_drain", 8'h30, q[0]);
            bus_write(8'h33, 8'h00, 1'b1);
            void'(q.pop_front());
        end
        rd_chk("wrap_empty", 8'h31, 8'h40);

        // Debounce: short glitch must not register
        bus_write(8'hF0, 8'h02, 1'b1);
        @(negedge CLK);
        BTN_RAW = 1'b1;
        repeat (10) @(negedge CLK);
        BTN_RAW = 1'b0;
        repeat (20) @(negedge CLK);
        rd_chk("glitch_pending", 8'h32, 8'h02);
        chk("glitch_irq", {7'b0, bus.INTERUPT_OUT}, 8'h00);

        // Debounce: long press raises the interrupt after 2+16+1 edges
        @(negedge CLK);
        BTN_RAW = 1'b1;
        seen = 1'b0;
        n = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge CLK);
            #1;
            if (bus.INTERUPT_OUT) begin
                seen = 1'b1;
                n = k;
            end
        end
        chk("btn_irq_seen", {7'b0, seen}, 8'h01);
        chk("btn_irq_latency", 8'(n), 8'd19);
        repeat (12) @(negedge CLK);
        BTN_RAW = 1'b0;
        repeat (30) @(negedge CLK);
        rd_chk("btn_pending", 8'h32, 8'h03);
        chk("btn_irq_held", {7'b0, bus.INTERUPT_OUT}, 8'h01);
        bus_write(8'hF0, 8'h03, 1'b1);
        rd_chk("ack_pending", 8'h32, 8'h02);
        @(negedge CLK);
        chk("ack_irq", {7'b0, bus.INTERUPT_OUT}, 8'h00);

        // FIFO-nonempty interrupt
        bus_write(8'hF0, 8'h04, 1'b1);
        push(8'hC3);
        @(negedge CLK);
        chk("fifo_irq_set", {7'b0, bus.INTERUPT_OUT}, 8'h01);
        rd_chk("fifo_irq_head", 8'h30, 8'hC3);
        bus_write(8'h33, 8'h00, 1'b1);
        @(negedge CLK);
        chk("fifo_irq_clr", {7'b0, bus.INTERUPT_OUT}, 8'h00);
        rd_chk("readback_leds", 8'h40, c_RB_LEDS);

        // Reset mid-stream with 3 bytes queued and the interrupt active
        push(8'h01);
        push(8'h02);
        push(8'h03);
        @(negedge CLK);
        rd_chk("pre_rst_status", 8'h31, 8'h03);
        chk("pre_rst_irq", {7'b0, bus.INTERUPT_OUT}, 8'h01);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_leds", LEDS, 8'h00);
        chk("mid_rst_sseg", SSEG_VAL, 8'h00);
        chk("mid_rst_irq", {7'b0, bus.INTERUPT_OUT}, 8'h00);
        chk("mid_rst_rx_ready", {7'b0, RX_READY}, 8'h01);
        rd_chk("mid_rst_status", 8'h31, 8'h40);
        rd_chk("mid_rst_irq_st", 8'h32, 8'h00);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        rd_chk("post_rst_status", 8'h31, 8'h40);
        chk("post_rst_irq", {7'b0, bus.INTERUPT_OUT}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rat_io_responder.md
Name: rat_io_responder

Overview:
Peripheral-side responder for the MCU's port I/O bus. It consumes PORT_ID/OUT_PORT/IO_STRB writes into output registers and control actions, and drives IN_PORT for IN instructions. It debounces a button into a latched interrupt request for INTERUPT_IN and buffers an external byte stream in a small FIFO that the CPU reads through ports. It sits at board top level between the MCU and the switches, LEDs, seven-segment display and byte source.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..64.
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed before the debounced button changes; >=2.

Ports:
CLK  in  1  system clock, same as the MCU.
RESET_N  in  1  asynchronous active-low reset.
PORT_ID  in  8  port address from the MCU.
OUT_PORT  in  8  write data from the MCU.
IO_STRB  in  1  one-cycle write strobe from the MCU.
IN_PORT  out  8  read data to the MCU; combinational from PORT_ID.
INTERUPT_OUT  out  1  level interrupt request to the MCU's INTERUPT_IN.
SWITCHES  in  8  slide switches, quasi-static.
BTN_RAW  in  1  asynchronous button input.
RX_DATA  in  8  byte from the external producer.
RX_VALID  in  1  producer has a byte.
RX_READY  out  1  FIFO can accept a byte (= !full).
LEDS  out  8  LED register.
SSEG_VAL  out  8  seven-segment value register.

Behaviour:
- Reset (RESET_N=0, async): LEDS=0, SSEG_VAL=0, FIFO empty (pointers 0, count 0), IRQ pending=0, IRQ mask=0, synchronizer and debounce state=0, debounce counter=0. INTERUPT_OUT=0 and RX_READY=1 while reset is held and after release.
- Write decode: acts only on the rising CLK edge with IO_STRB=1. Writes to undecoded ports are ignored.
  - 0x40: LEDS<=OUT_PORT.
  - 0x81: SSEG_VAL<=OUT_PORT.
  - 0xF0: IRQ control. Bit0=1 clears button pending. Bits[2:1]: mask <= OUT_PORT[2:1] (bit1 enables the button source, bit2 enables the FIFO-nonempty source).
  - 0x33: FIFO pop. Ignored if the FIFO is empty.
- Read decode: IN_PORT is combinational because the MCU samples it in the execute cycle with no read strobe.
  - 0x20 -> SWITCHES.
  - 0x30 -> FIFO head byte (0x00 if empty).
  - 0x31 -> {full, empty, 6'(count)}.
  - 0x32 -> {5'b0, mask_fifo, mask_btn, btn_pending}.
  - Any other port -> 0x00.
- Button: 2-flop synchronizer, then a counter that increments while the synced value differs from the debounced value. At DEBOUNCE_CYCLES the debounced value flips and the counter clears. The counter clears whenever the synced value equals the debounced value.
  - A 0->1 debounced edge sets btn_pending.
  - If set and clear occur in the same cycle, set wins.
- INTERUPT_OUT = (btn_pending & mask_btn) | (!empty & mask_fifo), registered, so 1-cycle latency from its cause. It is held high until cleared by ack or pop, which matches the MCU masking interrupts on entry.
- FIFO:
  - Push when RX_VALID & RX_READY.
  - Simultaneous push and pop on a non-empty FIFO: count unchanged, head advances, new byte is appended.
  - Push into an empty FIFO: the byte is visible on port 0x30 the next cycle.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits. Full when count==FIFO_DEPTH.
  - No overflow is possible because RX_READY gates the push.
- Reset mid-operation discards FIFO contents and pending interrupts immediately.

Optional Feature:
RAT_IO_READBACK_EN
- Defined: reads of 0x40 return LEDS and reads of 0x81 return SSEG_VAL.
- Undefined: both ports read 0x00 and no readback mux is built.

Test Plan:
- Reset: assert RESET_N=0 mid-stream with 3 bytes queued -> LEDS=0, SSEG_VAL=0, PORT_ID=0x31 reads 0x40 (empty=1, count=0), INTERUPT_OUT=0, RX_READY=1.
- Writes: IO_STRB pulse with PORT_ID=0x40, OUT_PORT=0xA5 -> LEDS=0xA5 next edge. Same data with IO_STRB=0 -> LEDS unchanged. PORT_ID=0x55 write -> no register changes.
- FIFO: push 0x11,0x22,...,0x88 (8 bytes) -> RX_READY=0, 0x31 reads 0x88. Pop eight times via 0x33 writes -> 0x30 reads the bytes in order, then empty with 0x31=0x40. A ninth pop leaves state unchanged.
- Simultaneous push/pop at count=3 -> count stays 3 and the head advances. Pointer wrap is checked after 20 push/pop pairs by data integrity.
- Debounce with DEBOUNCE_CYCLES=16 and mask_btn=1:
  - BTN_RAW glitch high for 10 cycles -> no pending.
  - Held high for 30 cycles -> pending=1; INTERUPT_OUT=1 within 2+16+1 cycles.
  - Write 0xF0 with 0x03 -> pending cleared and INTERUPT_OUT=0 next cycle.
- FIFO interrupt: mask=0b10 (write 0xF0=0x04), push 1 byte -> INTERUPT_OUT=1. Pop -> INTERUPT_OUT=0. With RAT_IO_READBACK_EN, read 0x40 -> 0xA5; without it -> 0x00.
